uart_rx_core: RTL
=================

Name: uart_rx_core

Overview:
Parametrised UART receiver. It replaces the fixed 8N1, 115200-baud receive path behind the top-level uart_rx pin. Data bits, parity mode, stop bits and baud divisor are set at elaboration. Received words are delivered over a valid/ready interface with per-word parity/frame status, plus overrun and break indications. It sits between the pad and the application logic / loopback to uart_txo.

Parameters:
CLK_FREQ, 125000000, system clock frequency in Hz
BAUD, 115200, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD, integer division (1085 at defaults); must be >= 8
DATA_BITS, 8, data bits per frame, legal 5..9, LSB first on the line
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
SYNC_STAGES, 2, input synchroniser depth, >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high
uart_rx  input  1  asynchronous serial line, idle high
out_data  output  DATA_BITS  received word
out_perr  output  1  parity error for the word in out_data
out_ferr  output  1  framing error (a stop bit sampled 0) for the word in out_data
out_valid  output  1  word available
out_ready  input  1  consumer accepts when out_valid && out_ready
overrun  output  1  one-cycle pulse: a completed word was dropped
break_det  output  1  one-cycle pulse: break frame detected
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset values: synchroniser flops = 1; FSM = IDLE; out_data = 0; out_perr/out_ferr/out_valid/overrun/break_det/busy = 0; bit counter and baud counter = 0.
- Reset asserted mid-frame aborts the frame. No output is produced. The holding register is cleared.
- rxs = uart_rx after SYNC_STAGES flops. Every decision below uses rxs.
- HALF = CLKS_PER_BIT/2 (542 at defaults).
- IDLE: when rxs == 0, clear baud counter and go to START.
- START: count to HALF-1, then sample rxs.
  - rxs == 1: glitch; return to IDLE with no output.
  - rxs == 0: go to DATA.
- DATA: sample every CLKS_PER_BIT cycles. Shift LSB first into the shift register. After DATA_BITS samples go to PARITY if PARITY != 0, else go to STOP.
- PARITY: one sample. perr = (XOR of data bits XOR parity bit) != (PARITY == 1 ? 1 : 0). With PARITY = 0, perr is always 0.
- STOP: STOP_BITS samples at CLKS_PER_BIT spacing. ferr = 1 if any stop sample is 0. FSM leaves STOP on the cycle of the final stop sample; no wait for the end of the stop bit.
  - ferr == 0: go to IDLE.
  - ferr == 1: go to WAIT_IDLE.
- WAIT_IDLE: stay until rxs == 1, then go to IDLE. No start detection while in this state.
- Break: all data bits 0, parity bit (if present) 0 and a stop sample 0. Result: break_det pulses for one cycle the cycle after the final stop sample. No word is delivered. FSM goes to WAIT_IDLE.
- Delivery: the cycle after the final stop sample (non-break frame), load out_data/out_perr/out_ferr and set out_valid = 1. Words with perr or ferr are still delivered.
- Handshake:
  - out_valid stays high, with stable data, until out_valid && out_ready.
  - On acceptance with no new word completing, out_valid drops the next cycle.
- Completion while the holding register is occupied:
  - out_ready == 1 in that cycle: the old word is accepted and the new word loads; out_valid stays 1 and no overrun.
  - out_ready == 0 in that cycle: the new word is discarded, the old word is kept, and overrun pulses for one cycle.
- Latency at defaults, 8N1: falling edge on uart_rx to out_valid = SYNC_STAGES + HALF + 9*CLKS_PER_BIT + 1 cycles (approximately).

Test Plan:
- Defaults, send 0xA5 8N1 (1085 clk/bit), out_ready = 1 -> exactly one out_valid pulse with out_data = 0xA5, out_perr = 0, out_ferr = 0, overrun = 0.
- PARITY = 2, send 0x37 with the parity bit forced wrong (0 instead of 1) -> out_data = 0x37, out_perr = 1; next frame 0x37 with correct parity -> out_perr = 0.
- Hold uart_rx = 0 for 400 cycles then high (start glitch < HALF) -> FSM returns to IDLE, no out_valid; busy is high during the 400-cycle low and returns low after the HALF-point sample.
- out_ready = 0, send 0x11 then 0x22 back-to-back -> out_data stays 0x11, one overrun pulse at the end of 0x22; raise out_ready -> 0x11 accepted, out_valid drops.
- Hold uart_rx low for 12 bit times, then high -> one break_det pulse, no out_valid; next frame 0x5A is received correctly. Also send 0x0F with stop bit 0 -> out_data = 0x0F, out_ferr = 1.
- DATA_BITS = 9, STOP_BITS = 2, send 0x1C3 -> out_data = 0x1C3; second stop bit driven 0 -> out_ferr = 1. Assert reset mid-data-bit -> no output, outputs at reset values, next frame received normally.

Source files
------------

// File: rtl/uart_rx_core.sv
// uart_rx_core: parametrised UART receiver. Oversamples the synchronised
// serial line with a baud counter, assembles LSB-first data words with
// optional parity and one or two stop bits, and hands each word to the
// application through a one-deep valid/ready holding register with
// parity/framing status, overrun and break indications.
module uart_rx_core #(
  parameter int CLK_FREQ    = 125000000,
  parameter int BAUD        = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_perr,
  output logic                 out_ferr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_e;

  // Line synchroniser and the synchronised line value used everywhere.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;

  // Receive FSM and datapath registers.
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       baud_cnt_q, baud_cnt_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_bit_q, par_bit_d;
  logic                   ferr_acc_q, ferr_acc_d;

  // Holding register and one-cycle indications.
  logic [DATA_BITS-1:0]   out_data_q, out_data_d;
  logic                   out_perr_q, out_perr_d;
  logic                   out_ferr_q, out_ferr_d;
  logic                   out_valid_q, out_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   break_q, break_d;

  // Frame-completion decisions made on the final stop sample.
  logic                   bit_tick;
  logic                   stop_bad;
  logic                   par_err;
  logic                   word_done;
  logic                   word_brk;

  // Shift the asynchronous line through SYNC_STAGES flops; reset to idle-high.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx};
    end
  end

  assign rxs      = sync_q[SYNC_STAGES-1];
  assign bit_tick = (baud_cnt_q == BIT_LAST);
  // Any stop sample low so far, including the one being taken this cycle.
  assign stop_bad = ferr_acc_q | ~rxs;
  assign par_err  = (PARITY != 0) && ((^{shift_q, par_bit_q}) != (PARITY == 1));

  // Next-state logic: frame sequencing, bit sampling and completion events.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    ferr_acc_d = ferr_acc_q;
    word_done  = 1'b0;
    word_brk   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          baud_cnt_d = '0;
          state_d    = S_START;
        end
      end

      S_START: begin
        if (baud_cnt_q == HALF_LAST) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          // A line that is high again at mid start bit was only a glitch.
          state_d    = rxs ? S_IDLE : S_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (bit_tick) begin
          baud_cnt_d = '0;
          shift_d    = {rxs, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d  = '0;
            ferr_acc_d = 1'b0;
            state_d    = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      S_PARITY: begin
        if (bit_tick) begin
          baud_cnt_d = '0;
          par_bit_d  = rxs;
          state_d    = S_STOP;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (bit_tick) begin
          baud_cnt_d = '0;
          ferr_acc_d = stop_bad;
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            // Leave on the final stop sample rather than the end of the bit,
            // so a back-to-back start edge is never missed.
            if (stop_bad && (shift_q == '0) && ((PARITY == 0) || !par_bit_q)) begin
              word_brk = 1'b1;
              state_d  = S_WAIT_IDLE;
            end else begin
              word_done = 1'b1;
              state_d   = stop_bad ? S_WAIT_IDLE : S_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      S_WAIT_IDLE: begin
        // A line still held low must not be mistaken for a new start bit.
        if (rxs) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Holding-register update: load on completion, drop on acceptance, flag drops.
  always_comb begin
    out_data_d  = out_data_q;
    out_perr_d  = out_perr_q;
    out_ferr_d  = out_ferr_q;
    out_valid_d = out_valid_q;
    overrun_d   = 1'b0;
    break_d     = word_brk;

    if (word_done) begin
      // Accepting the old word in the same cycle frees the slot for the new one.
      if (!out_valid_q || out_ready) begin
        out_data_d  = shift_q;
        out_perr_d  = par_err;
        out_ferr_d  = stop_bad;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State register for the FSM, datapath and holding register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its _d value from before the edge, independent of statement order.
    if (reset) begin
      state_q     <= S_IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_bit_q   <= 1'b0;
      ferr_acc_q  <= 1'b0;
      out_data_q  <= '0;
      out_perr_q  <= 1'b0;
      out_ferr_q  <= 1'b0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      break_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_bit_q   <= par_bit_d;
      ferr_acc_q  <= ferr_acc_d;
      out_data_q  <= out_data_d;
      out_perr_q  <= out_perr_d;
      out_ferr_q  <= out_ferr_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      break_q     <= break_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_perr  = out_perr_q;
  assign out_ferr  = out_ferr_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign break_det = break_q;
  assign busy      = (state_q != S_IDLE);

endmodule
